// File: rtl/ula_pkg.sv
// Shared ULA definitions: opcode encodings, flag bit positions and the sequencer state enum.
// Also provides the error predicate used when the frame is executed.
package ula_pkg;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_MUL = 8'h03;
    localparam logic [7:0] OP_DIV = 8'h04;
    localparam logic [7:0] OP_MOD = 8'h05;

    localparam int FLG_Z   = 0;
    localparam int FLG_C   = 1;
    localparam int FLG_S   = 2;
    localparam int FLG_P   = 3;
    localparam int FLG_V   = 6;
    localparam int FLG_ERR = 7;

    typedef enum logic [2:0] {
        FETCH_OP = 3'd0,
        FETCH_A  = 3'd1,
        FETCH_B  = 3'd2,
        EXEC     = 3'd3,
        DONE     = 3'd4
    } seq_state_e;

    // Unknown opcode, or a divide/modulo whose divisor is zero.
    function automatic logic op_err(input logic [7:0] opcode, input logic [7:0] operand_b);
        logic valid_op;
        logic div_like;
        valid_op = (opcode >= OP_ADD) && (opcode <= OP_MOD);
        div_like = (opcode == OP_DIV) || (opcode == OP_MOD);
        return !valid_op || (div_like && (operand_b == 8'h00));
    endfunction

endpackage

// File: rtl/ula_sequencer_if.sv
// Byte stream, ULA operand/result and result-port signals of the ULA sequencer.
// slave = sequencer side, master = surrounding environment (source, ULA, sink).
interface ula_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;

    logic [7:0]       ula_opcode;
    logic [7:0]       ula_a;
    logic [7:0]       ula_b;
    logic [7:0]       ula_result;
    logic [7:0]       ula_flags;

    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;
    logic [7:0]       res_flags;
    logic             res_err;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_data, in_valid, ula_result, ula_flags, res_ready,
        output in_ready, ula_opcode, ula_a, ula_b,
               res_valid, res_data, res_flags, res_err, op_count
    );

    modport master (
        output in_data, in_valid, ula_result, ula_flags, res_ready,
        input  in_ready, ula_opcode, ula_a, ula_b,
               res_valid, res_data, res_flags, res_err, op_count
    );
endinterface

// File: rtl/ula_sequencer.sv
// Assembles opcode/operand1/operand2 bytes into a ULA frame, executes for one cycle, holds the result.
// Latency: result valid one edge after the third byte; backpressure: in_ready low in EXEC/DONE, DONE held until res_ready.
// Result port holds its last capture after the handshake; op_count wraps silently.
module ula_sequencer
    import ula_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    ula_sequencer_if.slave bus
);

    seq_state_e       state_q,     state_d;
    logic             fetch_q,     fetch_d;
    logic [7:0]       opcode_q,    opcode_d;
    logic [7:0]       a_q,         a_d;
    logic [7:0]       b_q,         b_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_data_q,  res_data_d;
    logic [7:0]       res_flags_q, res_flags_d;
    logic             res_err_q,   res_err_d;
    logic [CNT_W-1:0] op_count_q,  op_count_d;

    logic             in_ready;
    logic             xfer;
    logic             exec_err;

    // fetch_q resets high so the sequencer is ready the first cycle after release;
    // gating with rst_n keeps in_ready low while reset is held.
    assign in_ready = fetch_q && rst_n;
    assign xfer     = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        fetch_d     = fetch_q;
        opcode_d    = opcode_q;
        a_d         = a_q;
        b_d         = b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        res_err_d   = res_err_q;
        op_count_d  = op_count_q;
        exec_err    = op_err(opcode_q, b_q);

        unique case (state_q)
            FETCH_OP: begin
                if (xfer) begin
                    opcode_d = bus.in_data;
                    state_d  = FETCH_A;
                end
            end
            FETCH_A: begin
                if (xfer) begin
                    a_d     = bus.in_data;
                    state_d = FETCH_B;
                end
            end
            FETCH_B: begin
                if (xfer) begin
                    b_d     = bus.in_data;
                    fetch_d = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // The ULA has seen stable operands for this whole cycle; sample it now.
                res_data_d  = exec_err ? 8'h00 : bus.ula_result;
                res_flags_d = {exec_err, bus.ula_flags[FLG_ERR-1:0]};
                res_err_d   = exec_err;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    op_count_d  = op_count_q + CNT_W'(1);
                    res_valid_d = 1'b0;
                    fetch_d     = 1'b1;
                    state_d     = FETCH_OP;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                fetch_d     = 1'b1;
                state_d     = FETCH_OP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_OP;
            fetch_q     <= 1'b1;
            opcode_q    <= 8'h00;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_flags_q <= 8'h00;
            res_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            fetch_q     <= fetch_d;
            opcode_q    <= opcode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            res_err_q   <= res_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.ula_opcode = opcode_q;
    assign bus.ula_a      = a_q;
    assign bus.ula_b      = b_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_flags  = res_flags_q;
    assign bus.res_err    = res_err_q;
    assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_ula_sequencer.sv
// Directed bench for ula_sequencer with a behavioural ULA and an expected-result queue.
module tb_ula_sequencer;
    import ula_pkg::*;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] flags;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    int   exp_cnt;
    exp_t sb[$];

    ula_sequencer_if #(.CNT_W(CNT_W)) bus ();

    ula_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ULA: {flags, result}. Flag bit7 is driven high to prove the sequencer overrides it.
    function automatic logic [15:0] ula_model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  w;
        logic [15:0] m;
        logic [7:0]  r;
        logic        c;
        logic        v;
        w = 9'd0; m = 16'd0; r = 8'd0; c = 1'b0; v = 1'b0;
        case (op)
            8'h01: begin
                w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            8'h02: begin
                w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            8'h03: begin
                m = {8'd0, a} * {8'd0, b}; r = m[7:0]; c = |m[15:8];
            end
            8'h04:   r = (b == 8'd0) ? 8'hFF : a / b;
            8'h05:   r = (b == 8'd0) ? a : a % b;
            default: r = 8'h5A;
        endcase
        return {1'b1, v, 2'b00, ~^r, r[7], c, (r == 8'd0), r};
    endfunction

    always_comb {bus.ula_flags, bus.ula_result} = ula_model(bus.ula_opcode, bus.ula_a, bus.ula_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        int waited;
        repeat (gap) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Sends a frame and queues the outcome the sequencer must report for it.
    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                              input int g1, input int g2);
        logic [15:0] u;
        logic        e;
        exp_t        x;
        u = ula_model(op, a, b);
        e = (op < 8'h01) || (op > 8'h05) || (((op == 8'h04) || (op == 8'h05)) && (b == 8'h00));
        x.err   = e;
        x.data  = e ? 8'h00 : u[7:0];
        x.flags = {e, u[14:8]};
        send_byte(op, 0);
        send_byte(a, g1);
        sb.push_back(x);
        send_byte(b, g2);
    endtask

    // Called right after the third byte; checks EXEC-cycle state and result latency.
    task automatic wait_result(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                               output exp_t got);
        int   i;
        exp_t x;
        got = '0;
        for (i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("exec_opcode", bus.ula_opcode, op);
                check("exec_a", bus.ula_a, a);
                check("exec_b", bus.ula_b, b);
                check("exec_in_ready", bus.in_ready, 0);
            end
            if (bus.res_valid) break;
        end
        check("result_latency", i, 2);
        if (!bus.res_valid) return;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        x = sb.pop_front();
        got = x;
        check("res_data", bus.res_data, x.data);
        check("res_flags", bus.res_flags, x.flags);
        check("res_err", bus.res_err, x.err);
    endtask

    task automatic handshake(input exp_t x, input int hold);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_res_valid", bus.res_valid, 1);
            check("hold_res_data", bus.res_data, x.data);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        exp_cnt++;
        @(negedge clk);
        check("post_res_valid", bus.res_valid, 0);
        check("post_in_ready", bus.in_ready, 1);
        check("post_op_count", bus.op_count, exp_cnt);
        check("post_res_data_kept", bus.res_data, x.data);
        check("post_res_err_kept", bus.res_err, x.err);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ula_opcode"}, bus.ula_opcode, 0);
        check({tag, "_ula_a"}, bus.ula_a, 0);
        check({tag, "_ula_b"}, bus.ula_b, 0);
        check({tag, "_res_data"}, bus.res_data, 0);
        check({tag, "_res_flags"}, bus.res_flags, 0);
        check({tag, "_op_count"}, bus.op_count, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_res_err"}, bus.res_err, 0);
        check({tag, "_in_ready"}, bus.in_ready, 0);
    endtask

    task automatic run_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                             input int hold, input logic [7:0] want);
        exp_t r;
        send_frame(op, a, b, 0, 0);
        wait_result(op, a, b, r);
        check("directed_res_data", bus.res_data, want);
        handshake(r, hold);
    endtask

    initial begin
        exp_t r;
        n_checks     = 0;
        n_err        = 0;
        exp_cnt      = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.res_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", bus.in_ready, 1);

        run_frame(8'h01, 8'h05, 8'h03, 0, 8'h08);   // ADD
        run_frame(8'h04, 8'h09, 8'h00, 0, 8'h00);   // DIV by zero
        check("div0_flag7", bus.res_flags[7], 1);
        run_frame(8'h04, 8'h09, 8'h03, 0, 8'h03);   // DIV
        run_frame(8'h07, 8'h01, 8'h01, 0, 8'h00);   // invalid opcode
        run_frame(8'h02, 8'h0A, 8'h04, 5, 8'h06);   // SUB with 5-cycle backpressure
        run_frame(8'h05, 8'h11, 8'h04, 0, 8'h01);   // remainder

        // Bubbled frame: valid pattern 1,0,0,1,0,1
        send_frame(8'h03, 8'h04, 8'h05, 2, 1);
        wait_result(8'h03, 8'h04, 8'h05, r);
        check("bubble_res_data", bus.res_data, 8'h14);
        handshake(r, 1);

        // Reset after two bytes discards the partial frame and the counter.
        send_byte(8'h04, 0);
        send_byte(8'h09, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        run_frame(8'h01, 8'h01, 8'h01, 0, 8'h02);
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ula_sequencer.md
# ula_sequencer

Byte-serial front end for the ULA. Assembles a three-byte frame (opcode, operand1, operand2) from an upstream valid/ready byte stream and holds it stable on the ULA input ports for one execute cycle. It then captures the ULA's combinational result and flags, adds error detection for invalid opcodes and division by zero, and presents the outcome on a valid/ready result port. It also counts completed operations.

## Interface
Parameters:
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  upstream byte (opcode, then operand1, then operand2).
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- ula_opcode  out  8  registered opcode driven to the ULA.
- ula_a  out  8  registered operand1 driven to the ULA.
- ula_b  out  8  registered operand2 driven to the ULA.
- ula_result  in  8  ULA combinational result.
- ula_flags  in  8  ULA combinational flags; bit7 is unused by the ULA.
- res_valid  out  1  result port holds a completed operation.
- res_ready  in  1  downstream accepts the result.
- res_data  out  8  captured result.
- res_flags  out  8  captured flags: bits 6:0 come from ula_flags, bit7 equals res_err.
- res_err  out  1  invalid opcode, or DIV/MOD with operand2 = 0.
- op_count  out  CNT_W  number of completed result handshakes; wraps.

## Operation
- FSM states: FETCH_OP, FETCH_A, FETCH_B, EXEC, DONE. The reset state is FETCH_OP.
- A byte transfers on in_valid && in_ready.
- FETCH_OP: on a transfer, load ula_opcode and go to FETCH_A.
- FETCH_A: on a transfer, load ula_a and go to FETCH_B.
- FETCH_B: on a transfer, load ula_b and go to EXEC.
- Fetch states hold position indefinitely while in_valid is low (bubbles allowed).
- in_ready = 1 only in the FETCH_* states and only while rst_n is high.
- EXEC lasts one cycle. At the end of EXEC, capture the outputs and go to DONE:
  - err = (opcode not in 8'h01..8'h05) || ((opcode == 8'h04 || opcode == 8'h05) && ula_b == 0).
  - res_data = err ? 8'h00 : ula_result.
  - res_flags = {err, ula_flags[6:0]}.
  - res_err = err.
- An invalid opcode still consumes both operand bytes. Framing is always exactly three bytes and never resynchronises.
- DONE: res_valid = 1. On res_ready, increment op_count and go to FETCH_OP.
- res_data, res_flags and res_err are stable throughout DONE and keep their last values after the handshake until the next capture.
- op_count wraps from all-ones to 0 without any flag.
- Reset while rst_n is low:
  - state = FETCH_OP.
  - ula_opcode, ula_a, ula_b, res_data, res_flags and op_count = 0.
  - res_valid = 0, res_err = 0, in_ready = 0.
- Reset asserted mid-frame or in DONE discards the partial frame or the pending result. The first byte after release is treated as an opcode.

## Timing
- The third byte is accepted at edge k. EXEC is the cycle between edges k and k+1, and the ULA inputs are stable for that whole cycle.
- The result is captured at edge k+1, and res_valid is high from edge k+1.
- Minimum frame-to-frame period is 5 cycles: 3 fetch cycles, 1 EXEC cycle, and at least 1 DONE cycle.
- in_ready is 0 in EXEC and DONE. If in_valid and res_ready are both high in DONE, no byte is taken that cycle; the byte is accepted in the following FETCH_OP cycle.
- ula_* outputs hold their values from capture until they are overwritten by the next frame's bytes.

## Structure
- The shared package `ula_pkg` holds:
  - opcode constants: OP_ADD = 8'h01, OP_SUB = 8'h02, OP_MUL = 8'h03, OP_DIV = 8'h04, OP_MOD = 8'h05.
  - flag bit indices: FLG_Z = 0, FLG_C = 1, FLG_S = 2, FLG_P = 3, FLG_V = 6, FLG_ERR = 7.
  - the FSM state enum.
- No sub-module. The ULA is instantiated alongside the sequencer by the parent, not inside it. Benches may connect the real ULA or a behavioural model.

## Test plan
- Reset, then bytes 01, 05, 03 with the real ULA → during EXEC, ula_opcode = 01, ula_a = 05, ula_b = 03. Then res_data = 08, res_flags[7] = 0, res_err = 0, and op_count = 1 after the handshake.
- Bytes 04, 09, 00 → res_err = 1, res_data = 00, res_flags[7] = 1.
- Bytes 04, 09, 03 → res_data = 03, res_err = 0.
- Bytes 07, 01, 01 → res_err = 1, res_data = 00. The next frame 02, 0A, 04 → res_data = 06.
- res_ready held low for 5 cycles after capture → res_valid stays 1, res_data is unchanged, and in_ready = 0. res_ready high → res_valid drops next edge, and in_ready = 1.
- Bubbles (in_valid pattern 1,0,0,1,0,1) on frame 03, 04, 05 → res_data = 14.
- rst_n pulsed low after two bytes → all outputs return to reset values. The next three bytes 01, 01, 01 → res_data = 02.
